weight_bram_sequencer: RTL and testbench

- Controller in front of one 16-bit x 28-word ANN weight BRAM. The BRAM has a single port with EN/WE and writes or reads on the falling clock edge.
- Shares that port between two requesters:
  - a host loader that writes single weights;
  - the neuron MAC datapath, which receives the full weight vector as a back-pressured stream.
- Sits between the weight-memory bank and the layer compute FSM; one instance per weight BRAM.

---
 rtl/weight_bram_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_weight_bram_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_sequencer.sv
// Weight BRAM port sequencer: arbitrates host single-word loads against a back-pressured
// full-vector read stream to the MAC datapath, using a 2-entry skid FIFO behind the BRAM.
module weight_bram_sequencer #(
   parameter int unsigned DEPTH  = 28,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] w_data_o,
   output logic              w_valid_o,
   input  logic              w_ready_i,
   output logic              w_last_o,
   input  logic              ld_req_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_data_i,
   output logic              ld_ack_o,
   output logic              ld_err_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [DATA_W-1:0] bram_di_o,
   output logic              bram_en_o,
   output logic              bram_we_o,
   input  logic [DATA_W-1:0] bram_do_i
);

   localparam int unsigned     CntW   = ADDR_W + 1;
   localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
   localparam logic [CntW-1:0] LastC  = CntW'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StFetch} state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     issue_cnt_q, issue_cnt_d;
   logic [CntW-1:0]     rd_cnt_q, rd_cnt_d;
   logic                inflight_q, inflight_d;
   logic [1:0]          fifo_cnt_q, fifo_cnt_d;
   logic [DATA_W-1:0]   slot0_q, slot0_d;
   logic [DATA_W-1:0]   slot1_q, slot1_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                w_valid_q, w_valid_d;
   logic                w_last_q, w_last_d;
   logic                ld_ack_q, ld_ack_d;
   logic                ld_err_q, ld_err_d;
   logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
   logic [DATA_W-1:0]   bram_di_q, bram_di_d;
   logic                bram_en_q, bram_en_d;
   logic                bram_we_q, bram_we_d;

   logic                pop, push, issue, ld_bad;
   logic [1:0]          occ, cnt_after_pop;

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      ld_ack_d    = 1'b0;
      ld_err_d    = 1'b0;
      bram_en_d   = 1'b0;
      bram_we_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      bram_di_d   = bram_di_q;
      issue       = 1'b0;

      pop           = (state_q == StFetch) && (fifo_cnt_q != 2'd0) && w_ready_i;
      push          = inflight_q;
      occ           = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      cnt_after_pop = fifo_cnt_q - {1'b0, pop};
      ld_bad        = ({1'b0, ld_addr_i} >= DepthC);

      unique case (state_q)
         StIdle: begin
            if (ld_req_i) begin
               state_d     = StLoad;
               bram_en_d   = 1'b1;
               bram_we_d   = !ld_bad;
               bram_addr_d = ld_addr_i;
               bram_di_d   = ld_data_i;
               ld_ack_d    = 1'b1;
               ld_err_d    = ld_bad;
            end else if (start_i) begin
               // FIFO and in-flight slot are empty here, so word 0 issues on the accept edge.
               state_d     = StFetch;
               busy_d      = 1'b1;
               rd_cnt_d    = '0;
               issue       = 1'b1;
               bram_en_d   = 1'b1;
               bram_addr_d = '0;
               issue_cnt_d = CntW'(1);
            end
         end
         StLoad: state_d = StIdle;
         StFetch: begin
            if ((issue_cnt_q < DepthC) && (occ < 2'd2)) begin
               issue       = 1'b1;
               bram_en_d   = 1'b1;
               bram_addr_d = issue_cnt_q[ADDR_W-1:0];
               issue_cnt_d = issue_cnt_q + CntW'(1);
            end
            if (pop) begin
               rd_cnt_d = rd_cnt_q + CntW'(1);
               if (rd_cnt_q == LastC) begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      inflight_d = issue;

      // Shift-register FIFO: slot0 is the head and drives w_data_o directly.
      slot0_d = pop ? slot1_q : slot0_q;
      slot1_d = slot1_q;
      if (push) begin
         if (cnt_after_pop == 2'd0) slot0_d = bram_do_i;
         else                       slot1_d = bram_do_i;
      end
      fifo_cnt_d = cnt_after_pop + {1'b0, push};

      w_valid_d = (fifo_cnt_d != 2'd0);
      w_last_d  = w_valid_d && (rd_cnt_d == LastC);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         issue_cnt_q <= '0;
         rd_cnt_q    <= '0;
         inflight_q  <= 1'b0;
         fifo_cnt_q  <= 2'd0;
         slot0_q     <= '0;
         slot1_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         ld_ack_q    <= 1'b0;
         ld_err_q    <= 1'b0;
         bram_addr_q <= '0;
         bram_di_q   <= '0;
         bram_en_q   <= 1'b0;
         bram_we_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         inflight_q  <= inflight_d;
         fifo_cnt_q  <= fifo_cnt_d;
         slot0_q     <= slot0_d;
         slot1_q     <= slot1_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         w_valid_q   <= w_valid_d;
         w_last_q    <= w_last_d;
         ld_ack_q    <= ld_ack_d;
         ld_err_q    <= ld_err_d;
         bram_addr_q <= bram_addr_d;
         bram_di_q   <= bram_di_d;
         bram_en_q   <= bram_en_d;
         bram_we_q   <= bram_we_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign w_data_o    = slot0_q;
   assign w_valid_o   = w_valid_q;
   assign w_last_o    = w_last_q;
   assign ld_ack_o    = ld_ack_q;
   assign ld_err_o    = ld_err_q;
   assign bram_addr_o = bram_addr_q;
   assign bram_di_o   = bram_di_q;
   assign bram_en_o   = bram_en_q;
   assign bram_we_o   = bram_we_q;

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// Directed bench for weight_bram_sequencer with a falling-edge BRAM model.
module tb_weight_bram_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic [15:0] w_data;
   logic        w_valid, w_last;
   logic        w_ready = 1'b0;
   logic        ld_req = 1'b0;
   logic [4:0]  ld_addr = '0;
   logic [15:0] ld_data = '0;
   logic        ld_ack, ld_err;
   logic [4:0]  bram_addr;
   logic [15:0] bram_di;
   logic        bram_en, bram_we;
   logic [15:0] bram_do = '0;

   logic [15:0] mem [32];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bram_en) begin
         if (bram_we) mem[bram_addr] <= bram_di;
         else         bram_do <= mem[bram_addr];
      end
   end

   weight_bram_sequencer dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .start_i     (start),
      .busy_o      (busy),
      .done_o      (done),
      .w_data_o    (w_data),
      .w_valid_o   (w_valid),
      .w_ready_i   (w_ready),
      .w_last_o    (w_last),
      .ld_req_i    (ld_req),
      .ld_addr_i   (ld_addr),
      .ld_data_i   (ld_data),
      .ld_ack_o    (ld_ack),
      .ld_err_o    (ld_err),
      .bram_addr_o (bram_addr),
      .bram_di_o   (bram_di),
      .bram_en_o   (bram_en),
      .bram_we_o   (bram_we),
      .bram_do_i   (bram_do)
   );

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy, done, w_valid, w_last, ld_ack, ld_err, bram_en, bram_we} !== 8'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000000",
                  {busy, done, w_valid, w_last, ld_ack, ld_err, bram_en, bram_we});
      end
      checks++;
      if (w_data !== 16'h0 || bram_addr !== 5'd0 || bram_di !== 16'h0) begin
         errors++;
         $display("FAIL reset_data got w_data=%h addr=%0d di=%h want 0", w_data, bram_addr,
                  bram_di);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_load;
      for (int a = 0; a < 28; a++) begin
         ld_req = 1'b1; ld_addr = 5'(a); ld_data = 16'h0100 + 16'(a);
         @(posedge clk); #1;
         checks++;
         if ({ld_ack, ld_err, bram_en, bram_we} !== 4'b1011 || bram_addr !== 5'(a) ||
             bram_di !== 16'h0100 + 16'(a)) begin
            errors++;
            $display("FAIL load_%0d got ack/err/en/we=%b addr=%0d di=%h want 1011 %0d %h", a,
                     {ld_ack, ld_err, bram_en, bram_we}, bram_addr, bram_di, a,
                     16'h0100 + 16'(a));
         end
         ld_req = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (ld_ack !== 1'b0 || bram_en !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse_%0d got ack=%b en=%b want 0 0", a, ld_ack, bram_en);
         end
      end
   endtask

   task automatic test_stream;
      w_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || w_valid !== 1'b0 || bram_en !== 1'b1 || bram_addr !== 5'd0) begin
         errors++;
         $display("FAIL stream_accept got busy=%b valid=%b en=%b addr=%0d want 1 0 1 0", busy,
                  w_valid, bram_en, bram_addr);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 28; i++) begin
         checks++;
         if (w_valid !== 1'b1 || w_data !== 16'h0100 + 16'(i) || w_last !== (i == 27) ||
             busy !== 1'b1) begin
            errors++;
            $display("FAIL stream_word_%0d got v=%b d=%h last=%b busy=%b want 1 %h %b 1", i,
                     w_valid, w_data, w_last, busy, 16'h0100 + 16'(i), (i == 27));
         end
         @(posedge clk); #1;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_done got done=%b busy=%b valid=%b want 1 0 0", done, busy,
                  w_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL stream_done_pulse got done=%b want 0", done);
      end
   endtask

   task automatic test_stall;
      logic [3:0] pat;
      int idx, outst, cyc;
      logic hs, stalled;
      pat = 4'b1001;
      idx = 0; cyc = 0; stalled = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      outst = (bram_en && !bram_we) ? 1 : 0;
      while (idx < 28 && cyc < 200) begin
         w_ready = pat[cyc % 4];
         if (stalled) begin
            checks++;
            if (w_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold_valid idx=%0d got %b want 1", idx, w_valid);
            end
         end
         if (w_valid) begin
            checks++;
            if (w_data !== 16'h0100 + 16'(idx) || w_last !== (idx == 27)) begin
               errors++;
               $display("FAIL stall_word_%0d got d=%h last=%b want %h %b", idx, w_data, w_last,
                        16'h0100 + 16'(idx), (idx == 27));
            end
         end
         hs = w_valid && w_ready;
         stalled = w_valid && !w_ready;
         @(posedge clk); #1;
         if (hs) begin idx++; outst--; end
         if (bram_en && !bram_we) outst++;
         checks++;
         if (outst > 2) begin
            errors++;
            $display("FAIL stall_outstanding cyc=%0d got %0d want <=2", cyc, outst);
         end
         cyc++;
      end
      checks++;
      if (idx != 28 || done !== 1'b1) begin
         errors++;
         $display("FAIL stall_complete got words=%0d done=%b want 28 1", idx, done);
      end
      w_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_collision;
      int n;
      ld_req = 1'b1; start = 1'b1; ld_addr = 5'd5; ld_data = 16'h0105;
      @(posedge clk); #1;
      checks++;
      if (ld_ack !== 1'b1 || bram_we !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL coll_drop_load got ack=%b we=%b busy=%b want 1 1 0", ld_ack, bram_we,
                  busy);
      end
      ld_req = 1'b0; start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b0 || bram_en !== 1'b0) begin
            errors++;
            $display("FAIL coll_drop_idle got busy=%b en=%b want 0 0", busy, bram_en);
         end
      end
      ld_req = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ld_ack !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL coll_held_load got ack=%b busy=%b want 1 0", ld_ack, busy);
      end
      ld_req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL coll_held_loadexit got busy=%b want 0", busy);
      end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL coll_held_start got busy=%b want 1", busy);
      end
      w_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (w_valid) begin
            checks++;
            if (w_data !== 16'h0100 + 16'(n)) begin
               errors++;
               $display("FAIL coll_word_%0d got %h want %h", n, w_data, 16'h0100 + 16'(n));
            end
            n++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (n != 28 || done !== 1'b1) begin
         errors++;
         $display("FAIL coll_burst got words=%0d done=%b want 28 1", n, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_bad_addr_and_ld_during_burst;
      int n;
      ld_req = 1'b1; ld_addr = 5'd30; ld_data = 16'hDEAD;
      @(posedge clk); #1;
      checks++;
      if ({ld_ack, ld_err, bram_en, bram_we} !== 4'b1110) begin
         errors++;
         $display("FAIL bad_addr got ack/err/en/we=%b want 1110",
                  {ld_ack, ld_err, bram_en, bram_we});
      end
      ld_req = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ld_err !== 1'b0 || ld_ack !== 1'b0) begin
         errors++;
         $display("FAIL bad_addr_pulse got ack=%b err=%b want 0 0", ld_ack, ld_err);
      end
      w_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ld_req = 1'b1; ld_addr = 5'd3; ld_data = 16'h0103;
      n = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         checks++;
         if (ld_ack !== 1'b0) begin
            errors++;
            $display("FAIL ld_in_burst cyc=%0d got ack=%b want 0", c, ld_ack);
         end
         if (w_valid) begin
            checks++;
            if (w_data !== 16'h0100 + 16'(n)) begin
               errors++;
               $display("FAIL reread_word_%0d got %h want %h", n, w_data, 16'h0100 + 16'(n));
            end
            n++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (n != 28 || done !== 1'b1 || ld_ack !== 1'b0) begin
         errors++;
         $display("FAIL reread_burst got words=%0d done=%b ack=%b want 28 1 0", n, done, ld_ack);
      end
      @(posedge clk); #1;
      checks++;
      if (ld_ack !== 1'b1 || ld_err !== 1'b0) begin
         errors++;
         $display("FAIL ld_after_done got ack=%b err=%b want 1 0", ld_ack, ld_err);
      end
      ld_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_burst;
      int n;
      logic saw_done;
      w_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      repeat (10) begin @(posedge clk); #1; end
      checks++;
      if (w_data !== 16'h010A || w_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_word10 got v=%b d=%h want 1 010a", w_valid, w_data);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, w_valid, w_last, ld_ack, ld_err, bram_en, bram_we} !== 8'b0 ||
          w_data !== 16'h0 || bram_addr !== 5'd0 || bram_di !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid_outputs got flags=%b d=%h addr=%0d di=%h want all 0",
                  {busy, done, w_valid, w_last, ld_ack, ld_err, bram_en, bram_we}, w_data,
                  bram_addr, bram_di);
      end
      saw_done = 1'b0;
      repeat (3) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
      checks++;
      if (saw_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_nodone got done_seen=%b busy=%b want 0 0", saw_done, busy);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (w_valid) begin
            checks++;
            if (w_data !== 16'h0100 + 16'(n)) begin
               errors++;
               $display("FAIL rst_restart_word_%0d got %h want %h", n, w_data,
                        16'h0100 + 16'(n));
            end
            n++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (n != 28 || done !== 1'b1) begin
         errors++;
         $display("FAIL rst_restart_burst got words=%0d done=%b want 28 1", n, done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back_start;
      int n, dones;
      w_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      n = 0; dones = 0;
      for (int c = 0; c < 60; c++) begin
         start = busy && (c % 5 == 2);
         if (w_valid) begin
            checks++;
            if (w_data !== 16'h0100 + 16'(n)) begin
               errors++;
               $display("FAIL restart_word_%0d got %h want %h", n, w_data, 16'h0100 + 16'(n));
            end
            n++;
         end
         @(posedge clk); #1;
         if (done) dones++;
      end
      start = 1'b0;
      checks++;
      if (n != 28 || dones != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_ignored got words=%0d dones=%0d busy=%b want 28 1 0", n, dones,
                  busy);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'hFFFF;
      test_reset();
      test_load();
      test_stream();
      test_stall();
      test_collision();
      test_bad_addr_and_ld_during_burst();
      test_reset_mid_burst();
      test_back_to_back_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
